// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the packed-matrix bus used by the matrix co-processor units.
// Elements are 8-bit signed values, laid out row-major from bit 0 of a 200-bit flat vector.
package matrix_pkg;

  localparam int ELEM_W    = 8;
  localparam int MAX_DIM   = 5;
  localparam int MAX_ELEMS = MAX_DIM * MAX_DIM;
  localparam int MAT_W     = MAX_ELEMS * ELEM_W;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  // Number of active elements (N*N) for a size code.
  function automatic logic [4:0] elem_count(input logic [1:0] size_code);
    logic [4:0] count;
    count = 5'd4;
    case (size_code)
      SIZE_2X2: count = 5'd4;
      SIZE_3X3: count = 5'd9;
      SIZE_4X4: count = 5'd16;
      SIZE_5X5: count = 5'd25;
      default:  count = 5'd4;
    endcase
    return count;
  endfunction

endpackage

// File: rtl/matrix_elem_add.sv
// One lane of the element-wise adder: wrapping 8-bit signed add with overflow detect.
// Both outputs are forced to zero when the lane lies outside the active matrix.
module matrix_elem_add
  import matrix_pkg::*;
(
  input  logic              active,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] sum,
  output logic              ovf
);

  logic [ELEM_W-1:0] raw_sum;
  logic              raw_ovf;

  assign raw_sum = a + b;
  // Same-sign operands producing an opposite-sign result means the true sum left -128..127.
  assign raw_ovf = (a[ELEM_W-1] == b[ELEM_W-1]) && (raw_sum[ELEM_W-1] != a[ELEM_W-1]);

  assign sum = active ? raw_sum : '0;
  assign ovf = active & raw_ovf;

endmodule

// File: rtl/matrix_adder.sv
// Element-wise signed adder for 2x2..5x5 matrices on the packed-matrix bus.
// Operands are captured on start; sum, overflow and a done pulse appear one clock later.
module matrix_adder
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAT_W-1:0] matrix_A,
  input  logic [MAT_W-1:0] matrix_B,
  input  logic [1:0]       matrix_size,
  output logic [MAT_W-1:0] result_out,
  output logic             overflow,
  output logic             done
);

  logic [4:0]           active_count;
  logic [MAX_ELEMS-1:0] active_mask;
  logic [MAX_ELEMS-1:0] elem_ovf;
  logic [MAT_W-1:0]     result_next;
  logic                 overflow_next;

  logic [MAT_W-1:0]     result_reg;
  logic                 overflow_reg;
  logic                 done_reg;

  assign active_count = elem_count(matrix_size);

  generate
    for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_lane
      localparam logic [4:0] LANE_IDX = 5'(gi);

      assign active_mask[gi] = (LANE_IDX < active_count);

      matrix_elem_add u_elem_add (
        .active (active_mask[gi]),
        .a      (matrix_A[gi*ELEM_W +: ELEM_W]),
        .b      (matrix_B[gi*ELEM_W +: ELEM_W]),
        .sum    (result_next[gi*ELEM_W +: ELEM_W]),
        .ovf    (elem_ovf[gi])
      );
    end
  endgenerate

  // Lanes already gate their own ovf, so a plain reduction covers only active elements.
  assign overflow_next = |elem_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= start;
      if (start) begin
        result_reg   <= result_next;
        overflow_reg <= overflow_next;
      end
    end
  end

  assign result_out = result_reg;
  assign overflow   = overflow_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_matrix_adder.sv
// Directed self-checking bench for matrix_adder with hand-computed expected sums.
module tb_matrix_adder;
  import matrix_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [MAT_W-1:0] matrix_A;
  logic [MAT_W-1:0] matrix_B;
  logic [1:0]       matrix_size;
  logic [MAT_W-1:0] result_out;
  logic             overflow;
  logic             done;

  int checks = 0;
  int errors = 0;

  int va [25];
  int vb [25];
  int vr [25];
  logic [MAT_W-1:0] exp_res;
  logic [MAT_W-1:0] exp_res2;

  matrix_adder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_A    (matrix_A),
    .matrix_B    (matrix_B),
    .matrix_size (matrix_size),
    .result_out  (result_out),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [MAT_W-1:0] pack25(input int v [25]);
    logic [MAT_W-1:0] p;
    logic [7:0]       e;
    p = '0;
    for (int i = 0; i < 25; i++) begin
      e = 8'(v[i]);
      p[i*8 +: 8] = e;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [MAT_W-1:0] r, input logic o, input logic d);
    $display("txn %s: result=%h overflow=%0b done=%0b", tag, result_out, overflow, done);
    chk({tag, ".result"}, result_out, r);
    chk({tag, ".overflow"}, {199'd0, overflow}, {199'd0, o});
    chk({tag, ".done"}, {199'd0, done}, {199'd0, d});
  endtask

  // Drive operands with start high on the falling edge, then sample 1 unit after the rising edge.
  task automatic issue(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b, input logic [1:0] sz);
    @(negedge clk);
    matrix_A    = a;
    matrix_B    = b;
    matrix_size = sz;
    start       = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b, input logic [1:0] sz);
    @(negedge clk);
    matrix_A    = a;
    matrix_B    = b;
    matrix_size = sz;
    start       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    matrix_A    = '0;
    matrix_B    = '0;
    matrix_size = SIZE_2X2;
    #1;
    chk_out("reset", '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 5x5 mixed overflow
    va = '{-90,-80,-70,-60,-50,-40,-30,-20,-10,-1,120,110,100,90,80,70,60,40,30,20,3,5,10,50,127};
    vb = '{10,9,8,7,6,5,4,3,2,1,10,20,20,10,10,50,40,30,20,10,5,10,20,60,1};
    vr = '{-80,-71,-62,-53,-44,-35,-26,-17,-8,0,-126,-126,120,100,90,120,100,70,50,30,8,15,30,110,-128};
    exp_res = pack25(vr);
    issue(pack25(va), pack25(vb), SIZE_5X5);
    chk_out("5x5_mixed", exp_res, 1'b1, 1'b1);
    idle_cycle('0, '0, SIZE_2X2);
    chk_out("5x5_after", exp_res, 1'b1, 1'b0);

    // 2x2 no overflow; upper elements carry junk that must be masked
    va = '{1,2,3,4,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100};
    vb = '{5,6,7,8,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100,100};
    vr = '{6,8,10,12,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_res = pack25(vr);
    issue(pack25(va), pack25(vb), SIZE_2X2);
    chk_out("2x2_plain", exp_res, 1'b0, 1'b1);
    chk("2x2_upper_zero", {32'd0, result_out[199:32]}, '0);

    // Hold: operands change with start low, outputs stay put
    for (int c = 0; c < 3; c++) begin
      idle_cycle({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, '1, SIZE_5X5);
      chk_out($sformatf("hold%0d", c), exp_res, 1'b0, 1'b0);
    end

    // Negative overflow 3x3
    va = '{-100,0,0,0,0,0,0,0,-128,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vb = '{-50,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vr = '{106,0,0,0,0,0,0,0,-128,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_res = pack25(vr);
    issue(pack25(va), pack25(vb), SIZE_3X3);
    chk_out("3x3_negovf", exp_res, 1'b1, 1'b1);

    // -128 + 0 alone at the last active 3x3 element: no overflow (back-to-back start)
    va = '{0,0,0,0,0,0,0,0,-128,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vb = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vr = '{0,0,0,0,0,0,0,0,-128,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_res = pack25(vr);
    issue(pack25(va), pack25(vb), SIZE_3X3);
    chk_out("3x3_min_noovf", exp_res, 1'b0, 1'b1);

    // Size masking: overflowing element 4 lies outside a 2x2
    va = '{0,0,0,0,127,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    vb = va;
    issue(pack25(va), pack25(vb), SIZE_2X2);
    chk_out("2x2_mask", '0, 1'b0, 1'b1);

    // Same operands as 4x4: element 4 now active and overflows (back-to-back)
    vr = '{0,0,0,0,-2,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    exp_res2 = pack25(vr);
    issue(pack25(va), pack25(vb), SIZE_4X4);
    chk_out("4x4_unmask", exp_res2, 1'b1, 1'b1);
    idle_cycle('0, '0, SIZE_2X2);
    chk_out("b2b_end", exp_res2, 1'b1, 1'b0);

    // Async reset after a 5x5 overflow result
    va = '{-90,-80,-70,-60,-50,-40,-30,-20,-10,-1,120,110,100,90,80,70,60,40,30,20,3,5,10,50,127};
    vb = '{10,9,8,7,6,5,4,3,2,1,10,20,20,10,10,50,40,30,20,10,5,10,20,60,1};
    issue(pack25(va), pack25(vb), SIZE_5X5);
    chk("pre_reset_ovf", {199'd0, overflow}, {199'd0, 1'b1});
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk_out("async_reset", '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("reset_start", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_out("post_reset", '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_adder.md
# matrix_adder

Element-wise signed adder for square matrices of 2x2 up to 5x5 8-bit elements, packed into 200-bit flat vectors. It sits in the matrix co-processor datapath beside the other matrix operation units and shares their packed-matrix bus format. A `start` strobe captures the operands. The registered sum and a sticky-per-operation overflow flag appear one clock later, qualified by `done`.

## Interface

- Parameters: none. Widths are fixed by package constants.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  capture operands and compute this cycle.
- `matrix_A`  in  200  signed operand A; element i at [i*8 +: 8], row-major.
- `matrix_B`  in  200  signed operand B; same layout.
- `matrix_size`  in  2  dimension N: 00→2, 01→3, 10→4, 11→5.
- `result_out`  out  200  signed element-wise sum, same layout.
- `overflow`  out  1  set if any active element overflowed.
- `done`  out  1  one-cycle pulse; `result_out`/`overflow` valid.

## Operation

- Active elements are indices 0 … N·N−1. They are packed contiguously from bit 0, so a 3x3 matrix uses elements 0–8 and bits [71:0].
- For each active i: `result_out[i] = (A[i] + B[i])` truncated to 8 bits (two's-complement wrap, no saturation).
- Per-element overflow = operands have the same sign and the sum sign differs, i.e. the true sum is outside −128…127.
- `overflow` is the OR of per-element overflow over active elements only.
- Inactive elements (i ≥ N·N):
  - their `result_out` bytes are driven 0;
  - their operand contents never affect `overflow`.
- `overflow` does not block the result; all active sums are written regardless.

## Timing

- Reset (async assert, sync-to-clk deassert by the system):
  - `result_out` = 0
  - `overflow` = 0
  - `done` = 0
- Latency 1 cycle: `start` high at edge k → at edge k+1 `result_out`/`overflow` are updated and `done` = 1.
- `done` is high for exactly one cycle per `start`.
- Back-to-back `start` is allowed every cycle: full throughput, `done` stays high, and each cycle shows the result of the previous cycle's operands.
- Without `start`, `result_out` and `overflow` hold their last values and `done` = 0.
- Operands and `matrix_size` are sampled only on the `start` edge. Changes on other cycles have no effect.
- Reset asserted mid-operation clears all outputs immediately. A `start` in the reset cycle is discarded.

## Structure

- Shared package `matrix_pkg`:
  - `ELEM_W = 8`, `MAX_DIM = 5`, `MAX_ELEMS = 25`, `MAT_W = 200`
  - size-code constants `SIZE_2X2` … `SIZE_5X5`
  - function mapping size code → N·N (4, 9, 16, 25)
- Sub-module `matrix_elem_add`, instantiated 25× via generate:
  - inputs: two 8-bit signed operands plus an `active` bit
  - outputs: 8-bit wrapped sum (0 when inactive) and a `ovf` bit (gated by `active`)
- Top level: active-mask generation from `matrix_size`, OR-reduction of `ovf`, and output/`done` registers.

## Test plan

- 5x5 mixed overflow:
  - A = −90,−80,−70,−60,−50,−40,−30,−20,−10,−1,120,110,100,90,80,70,60,40,30,20,3,5,10,50,127
  - B = 10,9,8,7,6,5,4,3,2,1,10,20,20,10,10,50,40,30,20,10,5,10,20,60,1
  - → result −80,−71,−62,−53,−44,−35,−26,−17,−8,0,−126,−126,120,100,90,120,100,70,50,30,8,15,30,110,−128; `overflow`=1
- 2x2 no overflow: A=1,2,3,4, B=5,6,7,8 → 6,8,10,12; bits [199:32]=0; `overflow`=0; `done` one cycle after `start`.
- Negative overflow, 3x3: element 0 = −100 + −50, others 0 → element 0 = 106, `overflow`=1; element 8 = −128 + 0 → −128 with no overflow.
- Size masking: size 00, element 4 = 127 + 127, elements 0–3 = 0 → `result_out`=0, `overflow`=0.
- Hold and handshake: `start` pulse, then operands changed with `start` low for 3 cycles → outputs unchanged, `done` low. Then `start` on consecutive cycles → `done` high each cycle with per-cycle results.
- Reset: after a 5x5 overflow result, assert `rst_n`=0 asynchronously → all outputs 0 before the next edge. A `start` in the reset cycle produces no `done`.
